conv5x5_bnn: RTL and testbench
==============================

CONV5X5_BNN -- requirements
Module: conv5x5_bnn

Interface
REQ-001 Parameters SHALL be: DW, 32, pixel width (signed); ACC_W, 37, result width (signed, lossless for 25 DW-bit terms).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  one column beat from the upstream 5-row window, accepted on any edge where high.
REQ-005 state  input  1  0: 28x28 image, 1: 12x12 image (same encoding as the upstream window).
REQ-006 taps  input  5*DW  column: taps[159:128]=row 0 (top/oldest) … taps[31:0]=row 4 (bottom/newest).
REQ-007 weight  input  25  binary kernel, bit r*5+c: 1 = +1, 0 = −1; r=0 top, c=0 leftmost (oldest column).
REQ-008 out_valid  output  1  out_data holds one valid convolution result this cycle.
REQ-009 out_data  output  ACC_W  signed 5x5 sum.
REQ-010 frame_done  output  1  single-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-011 The block SHALL keep raster counters row/col (0..N-1, N=28 or 12) advanced only on accepted beats; col wraps to 0 and row increments at col=N-1; after beat (N-1,N-1) both SHALL return to (0,0).
REQ-012 state and weight SHALL be latched into internal registers on the beat at (0,0); changes at any other time SHALL be ignored until the next frame's (0,0) beat.
REQ-013 A 5-column window register SHALL shift left by one column on each accepted beat, newest column entering at c=4; no shift without in_valid.
REQ-014 A beat at (row,col) with row>=4 and col>=4 SHALL produce exactly one result; all other beats SHALL produce none.
REQ-015 Result = sum over r,c of (weight bit ? +pix : −pix), sign-extended to ACC_W, no saturation, no truncation.
REQ-016 Pipeline: cycle t beat sampled (window + valid tag registered), t+1 five row partial sums registered, t+2 total registered; out_valid/out_data visible in cycle t+3 (latency 3).
REQ-017 Pipeline SHALL advance every cycle independent of in_valid (no backpressure); gaps between beats SHALL not alter results.
REQ-018 Results per frame SHALL be 576 (state 0) or 64 (state 1); frame_done SHALL assert with the result from beat (N-1,N-1).
REQ-019 out_data SHALL hold its last value while out_valid is low.
REQ-020 Back-to-back frames with no idle cycles SHALL be supported; first beat of frame k+1 may immediately follow the last beat of frame k.

Reset
REQ-021 On rst: row=col=0, pipeline valid tags=0, window registers=0, latched state=0, latched weight=0, out_valid=0, out_data=0, frame_done=0.
REQ-022 rst with in_valid high in the same cycle: rst wins, beat discarded.
REQ-023 rst mid-frame: in-flight results SHALL be dropped (no out_valid after the reset edge); next accepted beat is (0,0) of a new frame.

Verification
REQ-024 state=0, weight=all 1, taps all pixels=1, 784 contiguous beats -> 576 results each +25; first out_valid 3 cycles after beat 116; frame_done with result 576.
REQ-025 state=0, weight=all 0, all pixels=2 -> 576 results each −50.
REQ-026 state=1, weight=all 1, every pixel of column beat at col c = c, 144 beats -> 64 results; result at col c = 25c−50 (first = 50, last in row = 225); frame_done on 64th.
REQ-027 Scenario REQ-024 with in_valid high every other cycle -> identical 576 values, each out_valid exactly 3 cycles after its completing beat.
REQ-028 rst after 300 beats of a state-0 frame, then 784 new beats -> no output in the reset cycle or after it until 3 cycles after new beat 116; 576 correct results.
REQ-029 state and weight toggled at beat 400 of a state-0 frame -> frame still yields 576 results with original kernel; next frame uses new state/kernel.

Source files
------------

// File: rtl/conv5x5_bnn_if.sv
// Stream interface for the 5x5 binary-weight convolution block.
// master: drives column beats (in_valid, state, taps, weight), receives results.
// slave : receives column beats, drives out_valid, out_data and frame_done.
interface conv5x5_bnn_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned ACC_W = 37
);
  logic                    in_valid;
  logic                    state;
  logic [5*DW-1:0]         taps;
  logic [24:0]             weight;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    frame_done;

  modport master (
    output in_valid, state, taps, weight,
    input  out_valid, out_data, frame_done
  );

  modport slave (
    input  in_valid, state, taps, weight,
    output out_valid, out_data, frame_done
  );
endinterface

// File: rtl/conv5x5_bnn.sv
// 5x5 convolution with a binary (+1/-1) kernel over a column-serial image.
// Each accepted beat delivers one 5-pixel column; results appear three cycles
// after the beat that completes a valid 5x5 window.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of conv5x5_bnn_if (column beats in, results out)
module conv5x5_bnn #(
  parameter int unsigned DW    = 32,
  parameter int unsigned ACC_W = 37
) (
  input  logic          clk,
  input  logic          rst,
  conv5x5_bnn_if.slave  bus
);

  localparam int unsigned PSUM_W = DW + 3;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_28 = CNT_W'(27);
  localparam logic [CNT_W-1:0] LAST_12 = CNT_W'(11);
  localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(4);

  logic [CNT_W-1:0]         row;
  logic [CNT_W-1:0]         col;
  logic                     state_q;
  logic [24:0]              weight_q;

  logic signed [DW-1:0]     win [5][5];
  logic                     v0;
  logic                     last0;

  logic signed [PSUM_W-1:0] psum_c [5];
  logic signed [PSUM_W-1:0] psum   [5];
  logic                     v1;
  logic                     last1;

  logic signed [ACC_W-1:0]  total_c;

  logic                     at_origin_c;
  logic                     state_eff_c;
  logic [CNT_W-1:0]         n_last_c;
  logic                     col_end_c;
  logic                     row_end_c;
  logic                     emit_c;

  // Raster position decode; the (0,0) beat uses the incoming state directly
  // because that is the beat that latches it.
  always_comb begin
    at_origin_c = (row == '0) && (col == '0);
    state_eff_c = at_origin_c ? bus.state : state_q;
    n_last_c    = state_eff_c ? LAST_12 : LAST_28;
    col_end_c   = (col == n_last_c);
    row_end_c   = (row == n_last_c);
    emit_c      = (row >= FIRST_OUT) && (col >= FIRST_OUT);
  end

  // Raster counters and per-frame latched configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      state_q  <= 1'b0;
      weight_q <= '0;
    end else if (bus.in_valid) begin
      if (at_origin_c) begin
        state_q  <= bus.state;
        weight_q <= bus.weight;
      end
      if (col_end_c) begin
        col <= '0;
        row <= row_end_c ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  // Stage 0: window shift (newest column enters at c=4) and valid tag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
      v0    <= 1'b0;
      last0 <= 1'b0;
    end else begin
      v0    <= bus.in_valid && emit_c;
      last0 <= bus.in_valid && emit_c && row_end_c && col_end_c;
      if (bus.in_valid) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][4] <= bus.taps[(4-r)*DW +: DW];
        end
      end
    end
  end

  // Row partial sums: weight bit set adds the pixel, clear subtracts it
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      psum_c[r] = '0;
      for (int c = 0; c < 5; c++) begin
        if (weight_q[r*5+c]) begin
          psum_c[r] = psum_c[r] + PSUM_W'(win[r][c]);
        end else begin
          psum_c[r] = psum_c[r] - PSUM_W'(win[r][c]);
        end
      end
    end
  end

  // Stage 1: register row partial sums
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        psum[r] <= '0;
      end
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      for (int r = 0; r < 5; r++) begin
        psum[r] <= psum_c[r];
      end
      v1    <= v0;
      last1 <= v0 && last0;
    end
  end

  // Final accumulation of the five row sums
  always_comb begin
    total_c = '0;
    for (int r = 0; r < 5; r++) begin
      total_c = total_c + ACC_W'(psum[r]);
    end
  end

  // Stage 2: output register; data holds while no result is present
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= v1;
      bus.frame_done <= v1 && last1;
      if (v1) begin
        bus.out_data <= total_c;
      end
    end
  end

endmodule

// File: tb/tb_conv5x5_bnn.sv
// Self-checking bench for conv5x5_bnn: behavioural image-level model plus
// directed scenarios with literal expectations and randomized frames.
module tb_conv5x5_bnn;

  localparam int unsigned DW    = 32;
  localparam int unsigned ACC_W = 37;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv5x5_bnn_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

  conv5x5_bnn #(.DW(DW), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned due;
    longint      val;
    bit          last;
  } exp_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int unsigned cyc = 0;
  bit     armed = 1'b0;

  exp_t   expq[$];
  longint last_val = 0;

  // observation record for directed literal checks
  longint      got_q[$];
  int unsigned got_cyc_q[$];
  bit          got_fd_q[$];
  int unsigned beat116_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: image position from beat index, 5x5 sum over the
  // current row's stored columns.
  int     m_idx = 0;
  bit     m_st = 1'b0;
  logic [24:0] m_w = '0;
  longint rowcols [28][5];

  always @(posedge clk) begin : model
    int n, r, c;
    longint sum, pix;
    exp_t e;
    cyc++;
    if (rst) begin
      armed = 1'b1;
      m_idx = 0;
      expq.delete();
      last_val = 0;
    end else if (bus.in_valid) begin
      if (m_idx == 0) begin
        m_st = bus.state;
        m_w  = bus.weight;
      end
      n = m_st ? 12 : 28;
      r = m_idx / n;
      c = m_idx % n;
      for (int rr = 0; rr < 5; rr++) begin
        rowcols[c][rr] = longint'($signed(bus.taps[(4-rr)*DW +: DW]));
      end
      if (r >= 4 && c >= 4) begin
        sum = 0;
        for (int rr = 0; rr < 5; rr++) begin
          for (int cc = 0; cc < 5; cc++) begin
            pix = rowcols[c-4+cc][rr];
            sum = m_w[rr*5+cc] ? sum + pix : sum - pix;
          end
        end
        e.due  = cyc + 2;
        e.val  = sum;
        e.last = (m_idx == n*n - 1);
        expq.push_back(e);
      end
      m_idx = (m_idx + 1) % (n*n);
    end
  end

  // Compare process: every cycle once reset has been seen
  always @(negedge clk) begin : compare
    exp_t e;
    if (armed) begin
      if (bus.out_valid === 1'b1) begin
        got_q.push_back(longint'(bus.out_data));
        got_cyc_q.push_back(cyc);
        got_fd_q.push_back(bus.frame_done);
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("latency_cycle", longint'(cyc), longint'(e.due));
          chk("out_data", longint'(bus.out_data), e.val);
          chk("frame_done", longint'(bus.frame_done), longint'(e.last));
          last_val = e.val;
        end
      end else begin
        chk("out_valid_low", longint'(bus.out_valid), 0);
        chk("frame_done_idle", longint'(bus.frame_done), 0);
        chk("out_data_hold", longint'(bus.out_data), last_val);
        if (expq.size() > 0 && expq[0].due <= cyc) begin
          chk("missing_result_due", longint'(expq[0].due), longint'(cyc + 1));
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic clear_rec();
    got_q.delete();
    got_cyc_q.delete();
    got_fd_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.state    = 1'($urandom);
      bus.weight   = 25'($urandom);
      bus.taps     = {5{32'($urandom)}};
    end
  endtask

  // mode 0: every pixel = val, 1: pixel = column index, 2: random
  // gap 0: contiguous, 1: every other cycle, 2: random 0..2 idle cycles
  task automatic run_frame(input bit st, input logic [24:0] w, input int mode,
                           input longint val, input int gap, input int nbeats,
                           input int chg_at);
    int n;
    logic [5*DW-1:0] t;
    n = st ? 12 : 28;
    for (int k = 0; k < nbeats; k++) begin
      for (int rr = 0; rr < 5; rr++) begin
        case (mode)
          0:       t[(4-rr)*DW +: DW] = DW'(val);
          1:       t[(4-rr)*DW +: DW] = DW'(k % n);
          default: t[(4-rr)*DW +: DW] = DW'($urandom);
        endcase
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.taps     = t;
      if (chg_at >= 0 && k >= chg_at) begin
        bus.state  = ~st;
        bus.weight = ~w;
      end else begin
        bus.state  = st;
        bus.weight = w;
      end
      if (k == 116) beat116_cyc = cyc + 1;
      if (gap == 1) idle(1);
      else if (gap == 2) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic check_all(input string name, input longint v, input int from, input int to);
    for (int i = from; i < to && i < got_q.size(); i++) begin
      chk(name, got_q[i], v);
    end
  endtask

  task automatic count_fd(output int cnt);
    cnt = 0;
    foreach (got_fd_q[i]) if (got_fd_q[i]) cnt++;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int fd;
    bit rst_mid;
    int nb;
    bus.in_valid = 1'b0;
    bus.state    = 1'b0;
    bus.weight   = '0;
    bus.taps     = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_out_data", longint'(bus.out_data), 0);
    chk("reset_frame_done", longint'(bus.frame_done), 0);

    // all ones kernel, all pixels 1, contiguous
    clear_rec();
    run_frame(1'b0, '1, 0, 1, 0, 784, -1);
    idle(6);
    chk("s1_count", got_q.size(), 576);
    check_all("s1_val_plus25", 25, 0, 576);
    if (got_cyc_q.size() > 0) chk("s1_first_latency", got_cyc_q[0], beat116_cyc + 2);
    count_fd(fd);
    chk("s1_frame_done_count", fd, 1);
    if (got_fd_q.size() == 576) chk("s1_frame_done_last", got_fd_q[575], 1);

    // all zeros kernel, pixels 2
    clear_rec();
    run_frame(1'b0, '0, 0, 2, 0, 784, -1);
    idle(6);
    chk("s2_count", got_q.size(), 576);
    check_all("s2_val_minus50", -50, 0, 576);

    // 12x12, pixel = column index
    clear_rec();
    run_frame(1'b1, '1, 1, 0, 0, 144, -1);
    idle(6);
    chk("s3_count", got_q.size(), 64);
    if (got_q.size() == 64) begin
      chk("s3_first", got_q[0], 50);
      chk("s3_row_last", got_q[7], 225);
      chk("s3_col7_row2", got_q[16 + 3], 25*7 - 50);
      chk("s3_frame_done_64th", got_fd_q[63], 1);
    end
    count_fd(fd);
    chk("s3_frame_done_count", fd, 1);

    // gapped beats
    clear_rec();
    run_frame(1'b0, '1, 0, 1, 1, 784, -1);
    idle(6);
    chk("s4_count", got_q.size(), 576);
    check_all("s4_val_plus25", 25, 0, 576);

    // reset mid-frame with a beat presented during reset
    run_frame(1'b0, 25'h0AAAAAA, 2, 0, 0, 300, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.taps = {5{32'($urandom)}};
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    clear_rec();
    run_frame(1'b0, '1, 0, 1, 0, 784, -1);
    idle(6);
    chk("s5_count", got_q.size(), 576);
    check_all("s5_val_plus25", 25, 0, 576);
    if (got_cyc_q.size() > 0) chk("s5_first_latency", got_cyc_q[0], beat116_cyc + 2);

    // config change mid-frame is ignored; next frame picks it up
    clear_rec();
    run_frame(1'b0, '1, 0, 1, 0, 784, 400);
    run_frame(1'b1, '0, 0, 1, 0, 144, -1);
    idle(6);
    chk("s6_count", got_q.size(), 640);
    check_all("s6_old_kernel", 25, 0, 576);
    check_all("s6_new_kernel", -25, 576, 640);
    count_fd(fd);
    chk("s6_frame_done_count", fd, 2);

    // randomized frames, back-to-back, random gaps, occasional reset
    for (int f = 0; f < 8; f++) begin
      bit st;
      st = 1'($urandom);
      rst_mid = ($urandom_range(0, 3) == 0);
      nb = rst_mid ? int'($urandom_range(1, st ? 143 : 783)) : (st ? 144 : 784);
      run_frame(st, 25'($urandom), 2, 0, int'($urandom_range(0, 2)), nb,
                int'($urandom_range(0, 200)));
      if (rst_mid) begin
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
      end
    end
    idle(6);
    chk("final_queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
